icache_dm: RTL and testbench
============================

ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 Parameter: LINES, 16, number of one-word lines (power of two, 4..64).
REQ-002 Parameter: IDX_W, 4, log2(LINES); tag width is 30-IDX_W.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 rom_ce_i  input  1  CPU fetch enable.
REQ-007 rom_addr_i  input  32  CPU fetch byte address.
REQ-008 rom_data_o  output  32  instruction to CPU, combinational on hit.
REQ-009 stallreq_o  output  1  freeze request to pipeline, combinational.
REQ-010 inv_i  input  1  invalidate all lines (one-cycle pulse).
REQ-011 mem_req_o  output  1  refill request to instruction memory.
REQ-012 mem_addr_o  output  32  word-aligned refill address.
REQ-013 mem_ack_i  input  1  memory data valid, one-cycle pulse.
REQ-014 mem_data_i  input  32  refill word, sampled when mem_ack_i=1.
REQ-015 miss_cnt_o  output  32  saturating miss counter.

Function
REQ-016 Address split: bits[1:0] ignored, index = [IDX_W+1:2], tag = [31:IDX_W+2].
REQ-017 Hit = rom_ce_i & valid[index] & tag match & state IDLE; on hit rom_data_o = line data, stallreq_o=0, same cycle.
REQ-018 rom_ce_i=0: rom_data_o=0, stallreq_o=0, no lookup, no refill started.
REQ-019 FSM states IDLE, REFILL, DONE; encodings in shared defines.
REQ-020 IDLE, rom_ce_i=1, miss: stallreq_o=1 that cycle; next edge latch {addr[31:2],2'b00} into mem_addr_o, go REFILL.
REQ-021 REFILL: mem_req_o=1, mem_addr_o stable, stallreq_o=1 until mem_ack_i; no timeout.
REQ-022 REFILL with mem_ack_i=1: write mem_data_i, latched tag, valid=1 at latched index; mem_req_o deasserts next cycle; go DONE.
REQ-023 DONE: stallreq_o=1, rom_data_o=0, one cycle; then IDLE, where lookup repeats (hit if address unchanged).
REQ-024 Miss penalty: ack-latency + 2 cycles from first miss cycle to hit cycle; ack in first REFILL cycle gives 3 stalled cycles.
REQ-025 rom_addr_i change during REFILL: refill completes for latched address; new address re-looked-up in IDLE.
REQ-026 inv_i in IDLE or DONE: all valid bits cleared next edge; inv_i same cycle as hit still returns hit data that cycle.
REQ-027 inv_i in REFILL: all valid cleared; in-flight refill completes but its line stays invalid (sticky drop flag cleared in IDLE).
REQ-028 inv_i coinciding with mem_ack_i: line written, valid not set.
REQ-029 miss_cnt_o increments once per IDLE->REFILL transition; saturates at 32'hFFFF_FFFF.
REQ-030 mem_ack_i outside REFILL ignored.

Reset
REQ-031 rst=0 asynchronously: state IDLE, all valid=0, mem_req_o=0, mem_addr_o=0, miss_cnt_o=0, drop flag=0.
REQ-032 During reset rom_data_o=0, stallreq_o=0; data and tag arrays need not be cleared.
REQ-033 Reset mid-REFILL aborts: mem_req_o drops immediately; late mem_ack_i after release ignored.

Structure
REQ-034 Shared defines file gets ICache state encodings, default LINES/IDX_W, refill address alignment mask; reuse existing `RegBus and `InstAddrBus widths.
REQ-035 One sub-module icache_ram: LINES x (tag+32) array, one combinational read port, one synchronous write port; valid bits stay in icache_dm.
REQ-036 CPU-side ports connect directly to the processor's rom_ce_o/rom_addr_o/rom_data_i; stallreq_o feeds the pipeline stall controller.

Verification
REQ-037 Reset, fetch 0x0000_0000, ack after 2 cycles with 0x3401_1100 -> mem_addr_o=0x0, 4 stall cycles, then rom_data_o=0x3401_1100, miss_cnt_o=1.
REQ-038 Refetch 0x0000_0000 after fill -> hit same cycle, stallreq_o=0, mem_req_o stays 0, miss_cnt_o unchanged.
REQ-039 Fetch 0x0000_0040 (same index 0, different tag, LINES=16) -> miss, refill overwrites line 0; then 0x0 misses again, miss_cnt_o=3.
REQ-040 inv_i pulse during REFILL for 0x0000_0004 -> refill completes, next lookup of 0x4 misses again.
REQ-041 rst asserted while mem_req_o=1 -> mem_req_o=0 immediately, ack one cycle after release ignored, first fetch misses.
REQ-042 rom_ce_i=0 with random addresses -> rom_data_o=0, stallreq_o=0, no mem_req_o for 20 cycles.

Source files
------------

// File: rtl/icache_dm_pkg.sv
// Shared widths, state encodings and defaults for the direct-mapped
// instruction cache.
package icache_dm_pkg;

  localparam int REG_BUS_W   = 32;
  localparam int INST_ADDR_W = 32;

  localparam int IC_LINES = 16;
  localparam int IC_IDX_W = 4;

  localparam logic [INST_ADDR_W-1:0] IC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IC_IDLE   = 2'd0,
    IC_REFILL = 2'd1,
    IC_DONE   = 2'd2
  } ic_state_e;

endpackage

// File: rtl/icache_ram.sv
// Tag+data storage: one combinational read port, one synchronous
// write port. Contents are not reset; validity lives in the cache top.
module icache_ram
  import icache_dm_pkg::*;
#(
  parameter int LINES = IC_LINES,
  parameter int IDX_W = IC_IDX_W,
  parameter int TAG_W = 30 - IC_IDX_W
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [IDX_W-1:0]     waddr_i,
  input  logic [TAG_W-1:0]     wtag_i,
  input  logic [REG_BUS_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]     raddr_i,
  output logic [TAG_W-1:0]     rtag_o,
  output logic [REG_BUS_W-1:0] rdata_o
);

  logic [TAG_W+REG_BUS_W-1:0] mem_q [LINES];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= {wtag_i, wdata_i};
    end
  end

  assign {rtag_o, rdata_o} = mem_q[raddr_i];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped one-word-line instruction cache with a blocking
// IDLE/REFILL/DONE miss handler and a saturating miss counter.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int LINES = IC_LINES,
  parameter int IDX_W = IC_IDX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rom_ce_i,
  input  logic [INST_ADDR_W-1:0] rom_addr_i,
  output logic [REG_BUS_W-1:0]   rom_data_o,
  output logic                   stallreq_o,
  input  logic                   inv_i,
  output logic                   mem_req_o,
  output logic [INST_ADDR_W-1:0] mem_addr_o,
  input  logic                   mem_ack_i,
  input  logic [REG_BUS_W-1:0]   mem_data_i,
  output logic [31:0]            miss_cnt_o
);

  localparam int TAG_W = 30 - IDX_W;

  ic_state_e              state_q;
  logic [LINES-1:0]       valid_q;
  logic                   mem_req_q;
  logic [INST_ADDR_W-1:0] mem_addr_q;
  logic [31:0]            miss_cnt_q;
  logic                   drop_q;

  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     tag;
  logic [IDX_W-1:0]     w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic [TAG_W-1:0]     rd_tag;
  logic [REG_BUS_W-1:0] rd_data;
  logic                 hit;
  logic                 miss;
  logic                 refill_ack;
  logic                 unused_addr;

  assign idx   = rom_addr_i[IDX_W+1:2];
  assign tag   = rom_addr_i[31:IDX_W+2];
  assign w_idx = mem_addr_q[IDX_W+1:2];
  assign w_tag = mem_addr_q[31:IDX_W+2];

  assign unused_addr = ^rom_addr_i[1:0];

  assign hit = rom_ce_i & valid_q[idx]
             & (rd_tag == tag)
             & (state_q == IC_IDLE);
  assign miss = rom_ce_i & ~hit
              & (state_q == IC_IDLE);
  assign refill_ack = (state_q == IC_REFILL)
                    & mem_ack_i;

  assign rom_data_o = hit ? rd_data : '0;
  // Gated by rst so a held fetch does not stall the pipe in reset
  assign stallreq_o = rst
                    & ((state_q != IC_IDLE) | miss);

  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;
  assign miss_cnt_o = miss_cnt_q;

  icache_ram #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (refill_ack),
    .waddr_i (w_idx),
    .wtag_i  (w_tag),
    .wdata_i (mem_data_i),
    .raddr_i (idx),
    .rtag_o  (rd_tag),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IC_IDLE;
      valid_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      miss_cnt_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IC_IDLE: begin
          drop_q <= 1'b0;
          if (miss) begin
            state_q    <= IC_REFILL;
            mem_req_q  <= 1'b1;
            mem_addr_q <= rom_addr_i & IC_ALIGN_MASK;
            if (miss_cnt_q != 32'hFFFF_FFFF) begin
              miss_cnt_q <= miss_cnt_q + 32'd1;
            end
          end
        end
        IC_REFILL: begin
          if (inv_i) begin
            drop_q <= 1'b1;
          end
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            state_q   <= IC_DONE;
          end
        end
        IC_DONE: begin
          state_q <= IC_IDLE;
        end
        default: begin
          state_q <= IC_IDLE;
        end
      endcase
      // Invalidate wins over a coincident fill
      if (inv_i) begin
        valid_q <= '0;
      end else if (refill_ack && !drop_q) begin
        valid_q[w_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: fetches push expected words, a
// monitor pops them whenever the cache returns a hit.
module tb_icache_dm;

  logic        clk;
  logic        rst;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        stallreq_o;
  logic        inv_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic [31:0] miss_cnt_o;

  int n_chk;
  int n_fail;
  int ack_lat;
  bit auto_en;

  logic [31:0] exp_q [$];

  icache_dm #(
    .LINES (16),
    .IDX_W (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_i   (rom_ce_i),
    .rom_addr_i (rom_addr_i),
    .rom_data_o (rom_data_o),
    .stallreq_o (stallreq_o),
    .inv_i      (inv_i),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_ack_i  (mem_ack_i),
    .mem_data_i (mem_data_i),
    .miss_cnt_o (miss_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h3401_1100;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory responder
  initial begin
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk);
      if (auto_en && mem_req_o) begin
        repeat (ack_lat - 1) @(negedge clk);
        mem_data_i = mem_word(mem_addr_o);
        mem_ack_i  = 1'b1;
        @(negedge clk);
        mem_ack_i  = 1'b0;
      end
    end
  end

  // Monitor: every presented hit consumes one expected word
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst && rom_ce_i && !stallreq_o) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_hit: got %h expected none",
                   rom_data_o);
        end else begin
          chk("hit_data", rom_data_o, exp_q.pop_front());
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] a,
                       input logic [31:0] d,
                       input int exp_st);
    int   st;
    logic req_seen;
    logic [31:0] seen_addr;
    st        = 0;
    req_seen  = 1'b0;
    seen_addr = '0;
    exp_q.push_back(d);
    @(negedge clk);
    rom_ce_i   = 1'b1;
    rom_addr_i = a;
    #2;
    while (stallreq_o && st < 60) begin
      @(negedge clk);
      #2;
      if (mem_req_o) begin
        req_seen  = 1'b1;
        seen_addr = mem_addr_o;
      end
      st++;
    end
    if (st >= 60) begin
      n_chk++;
      n_fail++;
      $display("FAIL fetch_timeout: got %0d expected %0d",
               st, exp_st);
    end else begin
      chk("stall_cycles", st, exp_st);
    end
    chk("req_seen", {31'd0, req_seen},
        {31'd0, exp_st > 0});
    if (req_seen) chk("mem_addr", seen_addr, a & 32'hFFFF_FFFC);
    @(negedge clk);
    rom_ce_i = 1'b0;
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    ack_lat    = 2;
    auto_en    = 1'b1;
    rom_ce_i   = 1'b1;
    rom_addr_i = 32'h0;
    inv_i      = 1'b0;
    rst        = 1'b1;
    #1 rst     = 1'b0;

    // Reset state, fetch held high during reset
    repeat (3) @(negedge clk);
    #2;
    chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
    chk("rst_data", rom_data_o, 32'd0);
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_miss", miss_cnt_o, 32'd0);
    rom_ce_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Cold miss, ack in second refill cycle
    fetch(32'h0, 32'h3401_1100, 4);
    chk("miss_1", miss_cnt_o, 32'd1);
    fetch(32'h0, 32'h3401_1100, 0);
    chk("miss_hit", miss_cnt_o, 32'd1);

    // Conflict on index 0
    ack_lat = 1;
    fetch(32'h40, 32'h0040_FFBF, 3);
    fetch(32'h0, 32'h3401_1100, 3);
    chk("miss_3", miss_cnt_o, 32'd3);

    // Invalidate during refill: fill dropped, refetched
    ack_lat = 3;
    fork
      fetch(32'h4, 32'h0004_FFFB, 10);
      begin
        int w;
        w = 0;
        while (!mem_req_o && w < 20) begin
          @(negedge clk);
          w++;
        end
        if (w >= 20) begin
          n_chk++;
          n_fail++;
          $display("FAIL inv_wait: got %0d expected <20", w);
        end
        inv_i = 1'b1;
        @(negedge clk);
        inv_i = 1'b0;
      end
    join
    chk("miss_5", miss_cnt_o, 32'd5);
    ack_lat = 1;
    fetch(32'h4, 32'h0004_FFFB, 0);

    // Invalidate coincident with a hit still returns data
    exp_q.push_back(32'h0004_FFFB);
    @(negedge clk);
    rom_ce_i   = 1'b1;
    rom_addr_i = 32'h4;
    inv_i      = 1'b1;
    #2;
    chk("inv_hit_stall", {31'd0, stallreq_o}, 32'd0);
    @(negedge clk);
    inv_i    = 1'b0;
    rom_ce_i = 1'b0;
    fetch(32'h4, 32'h0004_FFFB, 3);
    chk("miss_6", miss_cnt_o, 32'd6);

    // Reset mid-refill, late ack ignored
    auto_en = 1'b0;
    @(negedge clk);
    rom_ce_i   = 1'b1;
    rom_addr_i = 32'h8;
    begin
      int w;
      w = 0;
      while (!mem_req_o && w < 10) begin
        @(negedge clk);
        w++;
      end
      chk("abort_req_up", {31'd0, mem_req_o}, 32'd1);
    end
    rst      = 1'b0;
    rom_ce_i = 1'b0;
    #1;
    chk("abort_req", {31'd0, mem_req_o}, 32'd0);
    chk("abort_miss", miss_cnt_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_data_i = 32'hDEAD_BEEF;
    mem_ack_i  = 1'b1;
    @(negedge clk);
    mem_ack_i = 1'b0;
    #2;
    chk("late_ack_req", {31'd0, mem_req_o}, 32'd0);
    auto_en = 1'b1;
    fetch(32'h8, 32'h0008_FFF7, 3);
    chk("miss_after_rst", miss_cnt_o, 32'd1);

    // Stray ack in IDLE must not corrupt the line
    @(negedge clk);
    mem_data_i = 32'hDEAD_BEEF;
    mem_ack_i  = 1'b1;
    @(negedge clk);
    mem_ack_i = 1'b0;
    fetch(32'h8, 32'h0008_FFF7, 0);

    // Fetch disabled: no output, no refill
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rom_ce_i   = 1'b0;
      rom_addr_i = $urandom;
      #2;
      chk("ce0_data", rom_data_o, 32'd0);
      chk("ce0_stall", {31'd0, stallreq_o}, 32'd0);
      chk("ce0_req", {31'd0, mem_req_o}, 32'd0);
    end
    chk("ce0_miss", miss_cnt_o, 32'd1);

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
